// File: rtl/mips_pkg.sv
// Shared MIPS-subset encodings and the decode helper for the ID stage.
// Holds opcode, funct, ALU control and compare-flag values.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLT = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;

  localparam logic [2:0] CMP_NONE = 3'd0;
  localparam logic [2:0] CMP_EQ   = 3'd1;

  typedef struct packed {
    logic       lw;
    logic       sw;
    logic       j;
    logic       illegal;
    logic       use_rs;
    logic       use_rt;
    logic       b_imm;
    logic [3:0] alu;
    logic [2:0] cmp;
    logic [4:0] rd;
  } ctl_t;

  function automatic ctl_t decode(
    input logic [5:0] op,
    input logic [5:0] fn,
    input logic [4:0] rt,
    input logic [4:0] rd
  );
    ctl_t c;
    c = '0;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        c.use_rs = 1'b1;
        c.use_rt = 1'b1;
        c.rd     = rd;
        unique case (1'b1)
          (fn == FN_ADD): c.alu = ALU_ADD;
          (fn == FN_SUB): c.alu = ALU_SUB;
          (fn == FN_AND): c.alu = ALU_AND;
          (fn == FN_OR):  c.alu = ALU_OR;
          (fn == FN_SLT): c.alu = ALU_SLT;
          default: begin
            c = '0;
            c.illegal = 1'b1;
          end
        endcase
      end
      (op == OP_ADDI), (op == OP_LW): begin
        c.use_rs = 1'b1;
        c.b_imm  = 1'b1;
        c.alu    = ALU_ADD;
        c.rd     = rt;
        c.lw     = (op == OP_LW);
      end
      (op == OP_SW): begin
        c.use_rs = 1'b1;
        c.use_rt = 1'b1;
        c.b_imm  = 1'b1;
        c.alu    = ALU_ADD;
        c.sw     = 1'b1;
      end
      (op == OP_BEQ): begin
        c.use_rs = 1'b1;
        c.use_rt = 1'b1;
        c.alu    = ALU_SUB;
        c.cmp    = CMP_EQ;
      end
      (op == OP_J): c.j = 1'b1;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read one-write register file, entry 0 hard-wired to zero.
// Optional same-cycle forwarding of the write port to both reads.
module regfile_2r1w #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int BYPASS_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2,
  input  logic              wen,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd
);

  localparam int N = 1 << REG_AW;

  logic [XLEN-1:0] mem [N];
  logic            wr_ok;
  logic            byp1;
  logic            byp2;

  assign wr_ok = wen && (wa != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wa] <= wd;
    end
  end

  assign byp1 = (BYPASS_EN != 0) && wr_ok && (wa == ra1);
  assign byp2 = (BYPASS_EN != 0) && wr_ok && (wa == ra2);

  assign rd1 = (ra1 == '0) ? '0 : (byp1 ? wd : mem[ra1]);
  assign rd2 = (ra2 == '0) ? '0 : (byp2 ? wd : mem[ra2]);

endmodule

// File: rtl/id_stage_param.sv
// MIPS-subset decode stage: register read, immediate build, load-use
// bubble and the registered decode/execute bundle.
module id_stage_param
  import mips_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int BYPASS_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       IR,
  input  logic [XLEN-1:0]   PC,
  input  logic              MW_wen,
  input  logic [REG_AW-1:0] MW_RD,
  input  logic [XLEN-1:0]   MW_ALUout,
  input  logic              DX_stall,
  output logic              id_ready,
  output logic              DX_valid,
  output logic              DX_lwFlag,
  output logic              DX_swFlag,
  output logic              DX_jFlag,
  output logic              DX_illegal,
  output logic [XLEN-1:0]   A,
  output logic [XLEN-1:0]   B,
  output logic [XLEN-1:0]   DX_SD,
  output logic [XLEN-1:0]   DX_IMM,
  output logic [XLEN-1:0]   DX_PC,
  output logic [REG_AW-1:0] RD,
  output logic [3:0]        ALUctr,
  output logic [2:0]        DX_compareFlag
);

  typedef struct packed {
    logic              valid;
    logic              lw;
    logic              sw;
    logic              j;
    logic              illegal;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [XLEN-1:0]   sd;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rd;
    logic [3:0]        alu;
    logic [2:0]        cmp;
  } dx_t;

  ctl_t              c;
  dx_t               q;
  dx_t               nx;
  logic [REG_AW-1:0] rs_a;
  logic [REG_AW-1:0] rt_a;
  logic [XLEN-1:0]   rs_val;
  logic [XLEN-1:0]   rt_val;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   jt;
  logic              hazard;

  assign c    = decode(IR[31:26], IR[5:0],
                       IR[20:16], IR[15:11]);
  assign rs_a = REG_AW'(IR[25:21]);
  assign rt_a = REG_AW'(IR[20:16]);
  assign imm  = {{(XLEN-16){IR[15]}}, IR[15:0]};
  assign jt   = {PC[XLEN-1:28], IR[25:0], 2'b00};

  regfile_2r1w #(
    .XLEN     (XLEN),
    .REG_AW   (REG_AW),
    .BYPASS_EN(BYPASS_EN)
  ) u_rf (
    .clk(clk),
    .rst(rst),
    .ra1(rs_a),
    .ra2(rt_a),
    .rd1(rs_val),
    .rd2(rt_val),
    .wen(MW_wen),
    .wa (MW_RD),
    .wd (MW_ALUout)
  );

  // A load still in DX cannot feed a consumer in ID this cycle.
  assign hazard = if_valid && q.valid && q.lw
               && (q.rd != '0)
               && ((c.use_rs && (q.rd == rs_a))
                || (c.use_rt && (q.rd == rt_a)));

  assign id_ready = rst && !DX_stall && !hazard;

  always_comb begin
    nx = '0;
    if (if_valid && !hazard) begin
      nx.pc = PC;
      if (c.illegal) begin
        nx.illegal = 1'b1;
      end else begin
        nx.valid = 1'b1;
        nx.lw    = c.lw;
        nx.sw    = c.sw;
        nx.j     = c.j;
        nx.alu   = c.alu;
        nx.cmp   = c.cmp;
        nx.rd    = REG_AW'(c.rd);
        nx.a     = c.use_rs ? rs_val : '0;
        nx.imm   = c.j ? jt : imm;
        nx.sd    = c.sw ? rt_val : '0;
        if (c.b_imm)       nx.b = imm;
        else if (c.use_rt) nx.b = rt_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           q <= '0;
    else if (!DX_stall) q <= nx;
  end

  assign DX_valid       = q.valid;
  assign DX_lwFlag      = q.lw;
  assign DX_swFlag      = q.sw;
  assign DX_jFlag       = q.j;
  assign DX_illegal     = q.illegal;
  assign A              = q.a;
  assign B              = q.b;
  assign DX_SD          = q.sd;
  assign DX_IMM         = q.imm;
  assign DX_PC          = q.pc;
  assign RD             = q.rd;
  assign ALUctr         = q.alu;
  assign DX_compareFlag = q.cmp;

endmodule

// File: tb/tb_id_stage_param.sv
// Directed bench for id_stage_param, with and without write bypass.
// Two instances share stimulus; expected values are hand-computed.
module tb_id_stage_param;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] IR;
  logic [31:0] PC;
  logic        MW_wen;
  logic [4:0]  MW_RD;
  logic [31:0] MW_ALUout;
  logic        DX_stall;

  logic        id_ready, DX_valid, DX_lwFlag, DX_swFlag;
  logic        DX_jFlag, DX_illegal;
  logic [31:0] A, B, DX_SD, DX_IMM, DX_PC;
  logic [4:0]  RD;
  logic [3:0]  ALUctr;
  logic [2:0]  DX_compareFlag;

  logic        n_ready, n_valid, n_lw, n_sw, n_j, n_ill;
  logic [31:0] n_a, n_b, n_sd, n_imm, n_pc;
  logic [4:0]  n_rd;
  logic [3:0]  n_alu;
  logic [2:0]  n_cmp;

  int total = 0;
  int bad   = 0;

  id_stage_param #(.XLEN(32), .REG_AW(5), .BYPASS_EN(1)) u_dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .IR(IR), .PC(PC),
    .MW_wen(MW_wen), .MW_RD(MW_RD), .MW_ALUout(MW_ALUout),
    .DX_stall(DX_stall), .id_ready(id_ready), .DX_valid(DX_valid),
    .DX_lwFlag(DX_lwFlag), .DX_swFlag(DX_swFlag),
    .DX_jFlag(DX_jFlag), .DX_illegal(DX_illegal),
    .A(A), .B(B), .DX_SD(DX_SD), .DX_IMM(DX_IMM), .DX_PC(DX_PC),
    .RD(RD), .ALUctr(ALUctr), .DX_compareFlag(DX_compareFlag)
  );

  id_stage_param #(.XLEN(32), .REG_AW(5), .BYPASS_EN(0)) u_nb (
    .clk(clk), .rst(rst), .if_valid(if_valid), .IR(IR), .PC(PC),
    .MW_wen(MW_wen), .MW_RD(MW_RD), .MW_ALUout(MW_ALUout),
    .DX_stall(DX_stall), .id_ready(n_ready), .DX_valid(n_valid),
    .DX_lwFlag(n_lw), .DX_swFlag(n_sw),
    .DX_jFlag(n_j), .DX_illegal(n_ill),
    .A(n_a), .B(n_b), .DX_SD(n_sd), .DX_IMM(n_imm), .DX_PC(n_pc),
    .RD(n_rd), .ALUctr(n_alu), .DX_compareFlag(n_cmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd,
      input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op,
      input logic [4:0] rs, input logic [4:0] rt,
      input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    MW_wen    = 1'b1;
    MW_RD     = r;
    MW_ALUout = v;
  endtask

  task automatic issue(input logic [31:0] ir, input logic [31:0] pc);
    if_valid = 1'b1;
    IR       = ir;
    PC       = pc;
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; IR = '0; PC = '0;
    MW_wen = 1'b0; MW_RD = '0; MW_ALUout = '0; DX_stall = 1'b0;
    #1 rst = 1'b0;
    #2;
    check("rst_valid", DX_valid, 0);
    check("rst_a", A, 0);
    check("rst_ready", id_ready, 0);
    check("rst_pc", DX_PC, 0);
    step();
    step();
    rst = 1'b1;

    // add r5,r3,r4 after writing r3=5, r4=7
    wr(3, 32'd5);
    step();
    wr(4, 32'd7);
    step();
    MW_wen = 1'b0;
    issue(rtype(3, 4, 5, 6'd32), 32'h10);
    #1 check("add_ready", id_ready, 1);
    step();
    check("add_a", A, 5);
    check("add_b", B, 7);
    check("add_rd", RD, 5);
    check("add_alu", ALUctr, 0);
    check("add_valid", DX_valid, 1);
    check("add_pc", DX_PC, 32'h10);
    check("add_nb_a", n_a, 5);

    // sub r6,r4,r3 while r1=0x100 is written
    issue(rtype(4, 3, 6, 6'd34), 32'h14);
    wr(1, 32'h100);
    step();
    MW_wen = 1'b0;
    check("sub_alu", ALUctr, 1);
    check("sub_a", A, 7);
    check("sub_b", B, 5);

    // lw r2,-4(r1) then dependent add r6,r2,r2
    issue(itype(6'd35, 1, 2, 16'hFFFC), 32'h18);
    step();
    check("lw_imm", DX_IMM, 32'hFFFFFFFC);
    check("lw_b", B, 32'hFFFFFFFC);
    check("lw_a", A, 32'h100);
    check("lw_flag", DX_lwFlag, 1);
    check("lw_rd", RD, 2);
    issue(rtype(2, 2, 6, 6'd32), 32'h1C);
    #1 check("hz_ready", id_ready, 0);
    step();
    check("bub_valid", DX_valid, 0);
    check("bub_lw", DX_lwFlag, 0);
    check("bub_ready", id_ready, 1);
    step();
    check("hz_add_valid", DX_valid, 1);
    check("hz_add_rd", RD, 6);
    check("hz_add_pc", DX_PC, 32'h1C);

    // same-cycle write-back forwarding
    if_valid = 1'b0;
    wr(7, 32'h55);
    step();
    wr(7, 32'h1234);
    issue(rtype(7, 0, 8, 6'd32), 32'h20);
    step();
    MW_wen = 1'b0;
    check("byp_a", A, 32'h1234);
    check("nobyp_a", n_a, 32'h55);
    check("byp_b", B, 0);

    // sw r4,8(r3) held by a 3-cycle stall
    issue(itype(6'd43, 3, 4, 16'd8), 32'h30);
    step();
    check("sw_flag", DX_swFlag, 1);
    check("sw_sd", DX_SD, 7);
    check("sw_b", B, 8);
    check("sw_a", A, 5);
    check("sw_rd", RD, 0);
    DX_stall = 1'b1;
    issue(itype(6'd8, 0, 9, 16'd1), 32'h34);
    wr(0, 32'hDEAD);
    #1 check("stall_ready", id_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_sw", DX_swFlag, 1);
      check("stall_pc", DX_PC, 32'h30);
      check("stall_sd", DX_SD, 7);
      check("stall_rdy", id_ready, 0);
    end
    DX_stall = 1'b0;
    MW_wen = 1'b0;
    step();
    check("addi_pc", DX_PC, 32'h34);
    check("r0_zero", A, 0);
    check("addi_b", B, 1);
    check("addi_rd", RD, 9);
    check("addi_sw", DX_swFlag, 0);

    // beq r3,r4
    issue(itype(6'd4, 3, 4, 16'h0010), 32'h36);
    step();
    check("beq_alu", ALUctr, 1);
    check("beq_cmp", DX_compareFlag, 1);
    check("beq_a", A, 5);
    check("beq_b", B, 7);
    check("beq_rd", RD, 0);

    // illegal opcode, then jump
    issue({6'h3F, 26'd0}, 32'h38);
    #1 check("ill_ready", id_ready, 1);
    step();
    check("ill_flag", DX_illegal, 1);
    check("ill_valid", DX_valid, 0);
    issue({6'd2, 26'h100}, 32'h40);
    step();
    check("j_imm", DX_IMM, 32'h400);
    check("j_flag", DX_jFlag, 1);
    check("j_ill", DX_illegal, 0);
    check("j_valid", DX_valid, 1);
    check("j_rd", RD, 0);

    // reset asserted during a stall
    DX_stall = 1'b1;
    issue(rtype(3, 4, 5, 6'd32), 32'h44);
    step();
    check("pre_rst_j", DX_jFlag, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_j", DX_jFlag, 0);
    check("arst_imm", DX_IMM, 0);
    check("arst_pc", DX_PC, 0);
    check("arst_valid", DX_valid, 0);
    check("arst_ready", id_ready, 0);
    rst = 1'b1;
    DX_stall = 1'b0;
    issue(itype(6'd8, 0, 11, 16'hFFFF), 32'h50);
    step();
    check("post_valid", DX_valid, 1);
    check("post_b", B, 32'hFFFFFFFF);
    check("post_rd", RD, 11);
    check("post_pc", DX_PC, 32'h50);
    issue(rtype(3, 4, 5, 6'd32), 32'h54);
    step();
    check("clr_a", A, 0);
    check("clr_b", B, 0);
    check("clr_rd", RD, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
